// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V control FSM.
// Contents: state_t (11 states, 4 bits), opcode constants, branch funct3 codes,
// datapath mux encodings and a helper that flags the memory-wait states.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StExecR   = 4'd2,
        StExecI   = 4'd3,
        StAluWb   = 4'd4,
        StMemAddr = 4'd5,
        StMemRd   = 4'd6,
        StMemWb   = 4'd7,
        StMemWr   = 4'd8,
        StBranch  = 4'd9,
        StJal     = 4'd10
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] ALU_A_PC    = 2'b00;
    localparam logic [1:0] ALU_A_OLDPC = 2'b01;
    localparam logic [1:0] ALU_A_RS1   = 2'b10;

    localparam logic [1:0] ALU_B_RS2  = 2'b00;
    localparam logic [1:0] ALU_B_IMM  = 2'b01;
    localparam logic [1:0] ALU_B_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    // States that hold mem_req until mem_ready and are watched by the wait timer.
    function automatic logic is_wait_state(input state_t st);
        return (st == StFetch) || (st == StMemRd) || (st == StMemWr);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory request/ready handshake between the control FSM and the memory port.
//   mem_req   : request active, held until mem_ready
//   mem_we    : write strobe, meaningful only with mem_req
//   mem_ready : memory completes the current request this cycle
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (output mem_req, output mem_we, input mem_ready);
    modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory wait timer: counts cycles spent waiting for mem_ready and flags the
// cycle in which the wait limit is reached.
//   i_clk    : clock
//   i_clr    : synchronous clear (reset, state change or expiry)
//   i_inc    : a wait cycle (request pending, no ready)
//   o_expire : this wait cycle is the last one allowed; 0 when MEM_TIMEOUT == 0
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TMR_W       = 4
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    generate
        if (MEM_TIMEOUT == 0) begin : g_no_guard
            assign o_expire = 1'b0;
        end else begin : g_guard
            localparam logic [TMR_W-1:0] LastCount = TMR_W'(MEM_TIMEOUT - 1);
            assign o_expire = i_inc && (r_count == LastCount);
        end
    endgenerate

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RISC-V datapath.
// Sequences fetch/decode/execute/memory/writeback, owns the branch decision and
// handshakes with memory, aborting a stalled access with a bus_err pulse.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_opcode, i_funct3  : instruction fields from IR
//   i_zero              : ALU zero flag (same cycle)
//   mem                 : memory handshake (master side)
//   o_pc_write, o_ir_write, o_reg_write : datapath load enables
//   o_alu_src_a/b, o_alu_op, o_result_src : datapath mux selects
//   o_illegal_instr, o_bus_err : one-cycle error pulses
//   o_state             : current state (debug)
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TMR_W       = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [6:0]                i_opcode,
    input  logic [2:0]                i_funct3,
    input  logic                      i_zero,
    multicycle_ctrl_if.master         mem,
    output logic                      o_pc_write,
    output logic                      o_ir_write,
    output logic                      o_reg_write,
    output logic [1:0]                o_alu_src_a,
    output logic [1:0]                o_alu_src_b,
    output logic [1:0]                o_alu_op,
    output logic [1:0]                o_result_src,
    output logic                      o_illegal_instr,
    output logic                      o_bus_err,
    output logic [3:0]                o_state
);

    state_t r_state;
    state_t w_next;
    logic   w_wait;
    logic   w_expire;
    logic   w_tmr_clr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_next;
        end
    end

    assign w_wait = is_wait_state(r_state) && !mem.mem_ready;
    // FETCH->FETCH after a timeout is not a state change, so expiry clears too.
    assign w_tmr_clr = i_rst || (w_next != r_state) || w_expire;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TMR_W      (TMR_W)
    ) u_timer (
        .i_clk   (i_clk),
        .i_clr   (w_tmr_clr),
        .i_inc   (w_wait),
        .o_expire(w_expire)
    );

    always_comb begin
        w_next          = r_state;
        o_pc_write      = 1'b0;
        o_ir_write      = 1'b0;
        o_reg_write     = 1'b0;
        mem.mem_req     = 1'b0;
        mem.mem_we      = 1'b0;
        o_alu_src_a     = ALU_A_PC;
        o_alu_src_b     = ALU_B_RS2;
        o_alu_op        = ALUOP_ADD;
        o_result_src    = RES_ALUOUT;
        o_illegal_instr = 1'b0;
        o_bus_err       = 1'b0;

        unique case (r_state)
            StFetch: begin
                mem.mem_req  = 1'b1;
                o_alu_src_a  = ALU_A_PC;
                o_alu_src_b  = ALU_B_FOUR;
                o_alu_op     = ALUOP_ADD;
                o_result_src = RES_ALU;
                if (mem.mem_ready) begin
                    o_ir_write = 1'b1;
                    o_pc_write = 1'b1;
                    w_next     = StDecode;
                end else if (w_expire) begin
                    o_bus_err = 1'b1;
                    w_next    = StFetch;
                end
            end
            StDecode: begin
                o_alu_src_a = ALU_A_OLDPC;
                o_alu_src_b = ALU_B_IMM;
                o_alu_op    = ALUOP_ADD;
                case (i_opcode)
                    OP_R:               w_next = StExecR;
                    OP_I:               w_next = StExecI;
                    OP_LOAD, OP_STORE:  w_next = StMemAddr;
                    OP_BRANCH:          w_next = StBranch;
                    OP_JAL:             w_next = StJal;
                    default: begin
                        o_illegal_instr = 1'b1;
                        w_next          = StFetch;
                    end
                endcase
            end
            StExecR: begin
                o_alu_src_a = ALU_A_RS1;
                o_alu_src_b = ALU_B_RS2;
                o_alu_op    = ALUOP_FUNCT;
                w_next      = StAluWb;
            end
            StExecI: begin
                o_alu_src_a = ALU_A_RS1;
                o_alu_src_b = ALU_B_IMM;
                o_alu_op    = ALUOP_FUNCT;
                w_next      = StAluWb;
            end
            StAluWb: begin
                o_reg_write  = 1'b1;
                o_result_src = RES_ALUOUT;
                w_next       = StFetch;
            end
            StMemAddr: begin
                o_alu_src_a = ALU_A_RS1;
                o_alu_src_b = ALU_B_IMM;
                o_alu_op    = ALUOP_ADD;
                w_next      = (i_opcode == OP_LOAD) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ready) begin
                    w_next = StMemWb;
                end else if (w_expire) begin
                    o_bus_err = 1'b1;
                    w_next    = StFetch;
                end
            end
            StMemWb: begin
                o_reg_write  = 1'b1;
                o_result_src = RES_MEMDATA;
                w_next       = StFetch;
            end
            StMemWr: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = 1'b1;
                if (mem.mem_ready) begin
                    w_next = StFetch;
                end else if (w_expire) begin
                    o_bus_err = 1'b1;
                    w_next    = StFetch;
                end
            end
            StBranch: begin
                o_alu_src_a  = ALU_A_RS1;
                o_alu_src_b  = ALU_B_RS2;
                o_alu_op     = ALUOP_SUB;
                o_result_src = RES_ALUOUT;
                w_next       = StFetch;
                case (i_funct3)
                    F3_BEQ:  o_pc_write = i_zero;
                    F3_BNE:  o_pc_write = !i_zero;
                    default: o_illegal_instr = 1'b1;
                endcase
            end
            StJal: begin
                // Target was left in ALUOut by DECODE; oldPC+4 goes into ALUOut now.
                o_pc_write   = 1'b1;
                o_result_src = RES_ALUOUT;
                o_alu_src_a  = ALU_A_OLDPC;
                o_alu_src_b  = ALU_B_FOUR;
                o_alu_op     = ALUOP_ADD;
                w_next       = StAluWb;
            end
            default: begin
                w_next = StFetch;
            end
        endcase

        // Reset masks everything combinationally so a pending access drops at once.
        if (i_rst) begin
            w_next          = StFetch;
            o_pc_write      = 1'b0;
            o_ir_write      = 1'b0;
            o_reg_write     = 1'b0;
            mem.mem_req     = 1'b0;
            mem.mem_we      = 1'b0;
            o_alu_src_a     = 2'b00;
            o_alu_src_b     = 2'b00;
            o_alu_op        = 2'b00;
            o_result_src    = 2'b00;
            o_illegal_instr = 1'b0;
            o_bus_err       = 1'b0;
        end
    end

    assign o_state = i_rst ? StFetch : r_state;

endmodule
